// File: rtl/mch_win_acc_pkg.sv
// Shared types and helpers for the windowed masked accumulator.
package mch_win_acc_pkg;

    // Window controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of one sample sum: an N_IN-word sum of DATA_W-bit words never overflows this.
    function automatic int sum_width(input int data_w, input int n_in);
        return data_w + $clog2(n_in);
    endfunction

endpackage

// File: rtl/mch_win_acc_masked_sum.sv
// Combinational masked adder: sums the input words whose mask bit is set.
module masked_sum
    import mch_win_acc_pkg::*;
#(
    parameter int DATA_W = 3,
    parameter int N_IN   = 2,
    parameter int SUM_W  = sum_width(DATA_W, N_IN)
) (
    input  logic [N_IN*DATA_W-1:0] data,
    input  logic [N_IN-1:0]        mask,
    output logic [SUM_W-1:0]       sum
);

    // Add each enabled word at full sum width so no carry is lost
    always_comb begin
        sum = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (mask[k]) begin
                sum = sum + SUM_W'(data[k*DATA_W +: DATA_W]);
            end
        end
    end

endmodule

// File: rtl/mch_win_acc.sv
// Windowed masked accumulator: sums a programmable number of masked samples,
// with wrap or saturate overflow handling and a sticky carry flag.
module mch_win_acc
    import mch_win_acc_pkg::*;
#(
    parameter int DATA_W = 3,
    parameter int N_IN   = 2,
    parameter int ACC_W  = 6,
    parameter int LEN_W  = 4
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic [N_IN*DATA_W-1:0] i_data,
    input  logic [N_IN-1:0]        i_mask,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic                   i_start,
    input  logic [LEN_W-1:0]       i_len,
    input  logic                   i_sat,
    input  logic                   i_clear,
    output logic [ACC_W-1:0]       o_data,
    output logic                   o_carry,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_busy
);

    localparam int SUM_W = sum_width(DATA_W, N_IN);
    localparam logic [LEN_W-1:0] LEN_ONE = 1;

    state_t             state;
    state_t             next_state;
    logic [LEN_W-1:0]   count;
    logic [LEN_W-1:0]   count_inc;
    logic [LEN_W-1:0]   len;
    logic               sat;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_next;
    logic               carry;
    logic [SUM_W-1:0]   sample_sum;
    logic [ACC_W:0]     total;
    logic               take;
    logic               launch;
    logic               last;

    masked_sum #(
        .DATA_W (DATA_W),
        .N_IN   (N_IN),
        .SUM_W  (SUM_W)
    ) u_sum (
        .data (i_data),
        .mask (i_mask),
        .sum  (sample_sum)
    );

    // One-bit-wider add exposes overflow; saturate clamps, wrap keeps the low bits
    always_comb begin
        total     = {1'b0, acc} + {{(ACC_W + 1 - SUM_W){1'b0}}, sample_sum};
        acc_next  = (sat && total[ACC_W]) ? '1 : total[ACC_W-1:0];
        count_inc = count + LEN_ONE;
        take      = (state == ACC) && i_valid;
        launch    = (state == IDLE) && i_start && (i_len != '0);
        last      = (count_inc == len);
    end

    // State register
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs; clear wins over every other request
    always_comb begin
        next_state = state;
        o_ready    = 1'b0;
        o_valid    = 1'b0;
        o_busy     = (state != IDLE);
        case (state)
            IDLE: begin
                if (launch) begin
                    next_state = ACC;
                end
            end
            ACC: begin
                o_ready = 1'b1;
                if (take && last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        if (i_clear) begin
            next_state = IDLE;
        end
    end

    // Accumulator, sample counter, sticky carry and latched window settings
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            acc   <= '0;
            carry <= 1'b0;
            count <= '0;
            len   <= '0;
            sat   <= 1'b0;
        end else if (i_clear) begin
            acc   <= '0;
            carry <= 1'b0;
            count <= '0;
        end else if (launch) begin
            acc   <= '0;
            carry <= 1'b0;
            count <= '0;
            len   <= i_len;
            sat   <= i_sat;
        end else if (take) begin
            acc   <= acc_next;
            carry <= carry | total[ACC_W];
            count <= count_inc;
        end
    end

    assign o_data  = acc;
    assign o_carry = carry;

endmodule

// File: tb/tb_mch_win_acc.sv
// Self-checking bench for mch_win_acc: table-driven windows plus corner sequences.
module tb_mch_win_acc;

    logic       clk = 1'b0;
    logic       i_rst;
    logic [5:0] i_data;
    logic [1:0] i_mask;
    logic       i_valid;
    logic       o_ready;
    logic       i_start;
    logic [3:0] i_len;
    logic       i_sat;
    logic       i_clear;
    logic [5:0] o_data;
    logic       o_carry;
    logic       o_valid;
    logic       i_ready;
    logic       o_busy;

    typedef struct {
        int len;
        bit sat;
        bit [1:0] mask;
        int w0;
        int w1;
        int gap;
        int hold;
        int exp_data;
        bit exp_carry;
    } vec_t;

    typedef struct {
        int data;
        int carry;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mch_win_acc #(
        .DATA_W (3),
        .N_IN   (2),
        .ACC_W  (6),
        .LEN_W  (4)
    ) dut (
        .clk     (clk),
        .i_rst   (i_rst),
        .i_data  (i_data),
        .i_mask  (i_mask),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_start (i_start),
        .i_len   (i_len),
        .i_sat   (i_sat),
        .i_clear (i_clear),
        .o_data  (o_data),
        .o_carry (o_carry),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_busy  (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, required, $time);
        end
    endtask

    // Wait a bounded number of cycles for o_valid, then score the result and hand it off
    task automatic collect_result(input int hold, inout int lat, input bit check_lat, input int exp_lat);
        bit   seen;
        exp_t e;
        seen = o_valid;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(posedge clk); #1; lat++;
            seen = o_valid;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL valid_timeout: got no o_valid, expected o_valid within 40 cycles");
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (check_lat) check_output("latency", lat, exp_lat);
        e = sb.pop_front();
        check_output("result_data", o_data, e.data);
        check_output("result_carry", o_carry, e.carry);
        repeat (hold) begin
            @(posedge clk); #1;
            check_output("hold_valid", o_valid, 1);
            check_output("hold_data", o_data, e.data);
        end
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        check_output("post_valid", o_valid, 0);
        check_output("post_busy", o_busy, 0);
        check_output("idle_data_held", o_data, e.data);
        check_output("idle_carry_held", o_carry, e.carry);
    endtask

    // Run one complete window from a table entry
    task automatic apply_stimulus(input vec_t v);
        int lat;
        @(negedge clk);
        i_start = 1'b1;
        i_len   = 4'(v.len);
        i_sat   = v.sat;
        sb.push_back('{v.exp_data, int'(v.exp_carry)});
        lat = 0;
        @(posedge clk); #1; lat++;
        i_start = 1'b0;
        for (int s = 0; s < v.len; s++) begin
            i_data  = {3'(v.w1), 3'(v.w0)};
            i_mask  = v.mask;
            i_valid = 1'b1;
            @(posedge clk); #1; lat++;
            i_valid = 1'b0;
            if (s != v.len - 1) begin
                repeat (v.gap) begin
                    @(posedge clk); #1; lat++;
                end
            end
        end
        collect_result(v.hold, lat, v.gap == 0, v.len + 1);
    endtask

    // Watch a few idle cycles and count any stray o_valid
    task automatic expect_quiet(input string name, input int cycles);
        int stray;
        stray = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (o_valid) stray++;
        end
        check_output(name, stray, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        vecs[0] = '{3,  1'b0, 2'b11, 5, 7, 0, 0, 36, 1'b0};
        vecs[1] = '{6,  1'b0, 2'b11, 7, 7, 0, 0, 20, 1'b1};
        vecs[2] = '{6,  1'b1, 2'b11, 7, 7, 0, 5, 63, 1'b1};
        vecs[3] = '{2,  1'b0, 2'b01, 3, 7, 2, 0, 6,  1'b0};
        vecs[4] = '{4,  1'b0, 2'b00, 7, 7, 0, 0, 0,  1'b0};
        vecs[5] = '{1,  1'b0, 2'b10, 2, 6, 0, 0, 6,  1'b0};
        vecs[6] = '{5,  1'b1, 2'b10, 7, 2, 1, 0, 10, 1'b0};
        vecs[7] = '{15, 1'b0, 2'b11, 2, 3, 0, 0, 11, 1'b1};

        i_rst = 1'b1; i_data = '0; i_mask = '0; i_valid = 1'b0; i_start = 1'b0;
        i_len = '0; i_sat = 1'b0; i_clear = 1'b0; i_ready = 1'b0;
        #2;
        check_output("reset_data", o_data, 0);
        check_output("reset_carry", o_carry, 0);
        check_output("reset_valid", o_valid, 0);
        check_output("reset_ready", o_ready, 0);
        check_output("reset_busy", o_busy, 0);
        @(negedge clk); @(negedge clk);
        i_rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i]);
        end

        // Zero-length start is ignored
        @(negedge clk);
        i_start = 1'b1; i_len = 4'd0; i_sat = 1'b0;
        @(posedge clk); #1;
        i_start = 1'b0;
        check_output("len0_busy", o_busy, 0);
        check_output("len0_ready", o_ready, 0);

        // A second start mid-window must not relatch length or mode
        @(negedge clk);
        i_start = 1'b1; i_len = 4'd2; i_sat = 1'b0;
        sb.push_back('{4, 0});
        lat = 0;
        @(posedge clk); #1; lat++;
        i_data = {3'd1, 3'd1}; i_mask = 2'b11; i_valid = 1'b1;
        i_start = 1'b1; i_len = 4'd5; i_sat = 1'b1;
        @(posedge clk); #1; lat++;
        i_start = 1'b0;
        @(posedge clk); #1; lat++;
        i_valid = 1'b0;
        collect_result(0, lat, 1'b1, 3);

        // Abort after one of four samples, with clear and start together
        @(negedge clk);
        i_start = 1'b1; i_len = 4'd4; i_sat = 1'b0;
        @(posedge clk); #1;
        i_start = 1'b0;
        i_data = {3'd7, 3'd5}; i_mask = 2'b11; i_valid = 1'b1;
        @(posedge clk); #1;
        check_output("abort_partial", o_data, 12);
        i_clear = 1'b1; i_start = 1'b1; i_len = 4'd2; i_ready = 1'b1;
        @(posedge clk); #1;
        i_clear = 1'b0; i_start = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        check_output("abort_busy", o_busy, 0);
        check_output("abort_data", o_data, 0);
        check_output("abort_carry", o_carry, 0);
        check_output("abort_valid", o_valid, 0);
        expect_quiet("abort_no_valid", 6);

        // Asynchronous reset mid-window
        @(negedge clk);
        i_start = 1'b1; i_len = 4'd4; i_sat = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        i_data = {3'd7, 3'd5}; i_mask = 2'b11; i_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_output("pre_reset_data", o_data, 24);
        #2;
        i_rst = 1'b1;
        #1;
        check_output("async_rst_data", o_data, 0);
        check_output("async_rst_carry", o_carry, 0);
        check_output("async_rst_valid", o_valid, 0);
        check_output("async_rst_ready", o_ready, 0);
        check_output("async_rst_busy", o_busy, 0);
        @(negedge clk);
        i_rst = 1'b0; i_valid = 1'b0;
        expect_quiet("reset_no_valid", 6);
        check_output("reset_after_busy", o_busy, 0);

        // Normal operation resumes after reset
        apply_stimulus(vecs[0]);

        check_output("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
